// File: rtl/switch_input_conditioner.sv
// Slide-switch conditioner: per-bit synchroniser, saturating debounce counter and a
// registered output word with change strobe/mask. Define SW_EDGE_LATCH_EN for the sticky edge record.
module switch_input_conditioner #(
   parameter int WIDTH           = 16,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw_raw,
   input  logic             hold,
   input  logic             clr_edges,
   output logic [WIDTH-1:0] sw,
   output logic             sw_changed,
   output logic [WIDTH-1:0] changed_mask,
   output logic [WIDTH-1:0] edge_latched
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
   logic [WIDTH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0]                  deb_q, deb_d;
   logic [WIDTH-1:0]                  sw_q, sw_d;
   logic                              sw_changed_q, sw_changed_d;
   logic [WIDTH-1:0]                  changed_mask_q, changed_mask_d;
   logic [WIDTH-1:0]                  edge_latched_q, edge_latched_d;
   logic [WIDTH-1:0]                  syn_s;

   assign syn_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = sw_raw;
      for (int s = 1; s < SYNC_STAGES; s++) begin
         sync_d[s] = sync_q[s-1];
      end
   end

   // Counter restarts whenever the synchronised level returns to the accepted one,
   // so bounce only gets through once it has been steady for the whole window.
   always_comb begin
      deb_d = deb_q;
      cnt_d = cnt_q;
      for (int i = 0; i < WIDTH; i++) begin
         if (syn_s[i] == deb_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            deb_d[i] = syn_s[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   // Output compares against the next debounced value so the strobe lands with the new word.
   always_comb begin
      sw_d           = sw_q;
      sw_changed_d   = 1'b0;
      changed_mask_d = '0;
      if (!hold && (deb_d != sw_q)) begin
         sw_d           = deb_d;
         sw_changed_d   = 1'b1;
         changed_mask_d = sw_q ^ deb_d;
      end else begin
         sw_changed_d   = 1'b0;
         changed_mask_d = '0;
      end
   end

`ifdef SW_EDGE_LATCH_EN
   // New changes are OR-ed in after the clear, so a coincident event survives.
   always_comb begin
      edge_latched_d = (edge_latched_q & ~{WIDTH{clr_edges}}) | changed_mask_d;
   end
`else
   logic unused_clr_edges_s;
   assign unused_clr_edges_s = clr_edges;

   always_comb begin
      edge_latched_d = '0;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q         <= '0;
         cnt_q          <= '0;
         deb_q          <= '0;
         sw_q           <= '0;
         sw_changed_q   <= 1'b0;
         changed_mask_q <= '0;
         edge_latched_q <= '0;
      end else begin
         sync_q         <= sync_d;
         cnt_q          <= cnt_d;
         deb_q          <= deb_d;
         sw_q           <= sw_d;
         sw_changed_q   <= sw_changed_d;
         changed_mask_q <= changed_mask_d;
         edge_latched_q <= edge_latched_d;
      end
   end

   assign sw           = sw_q;
   assign sw_changed   = sw_changed_q;
   assign changed_mask = changed_mask_q;
   assign edge_latched = edge_latched_q;

endmodule
